turn_sequencer: RTL and testbench

//  Requesting end of the board-update handshake: accepts player moves/passes, checks legality, issues one

---
 rtl/turn_sequencer_if.sv | 33 +++
 rtl/turn_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_turn_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_sequencer_if.sv
// Player-input, board-updater handshake and game-status signals of turn_sequencer.
// master: the sequencer itself; slave: player input logic, updater and display side.
interface turn_sequencer_if;
    logic                   move_valid;
    logic                   pass_in;
    logic [7:0]             move_in;
    logic                   move_ready;

    logic                   upd_start;
    logic [7:0]             upd_move;
    logic                   upd_turn;
    logic [8:0][8:0][1:0]   upd_board;
    logic [8:0][8:0][1:0]   upd_next_board;
    logic                   upd_ready;

    logic [8:0][8:0][1:0]   board_out;
    logic                   turn_out;
    logic [8:0]             move_count;
    logic                   illegal_pulse;
    logic                   game_over;

    modport master (
        input  move_valid, pass_in, move_in, upd_next_board, upd_ready,
        output move_ready, upd_start, upd_move, upd_turn, upd_board,
               board_out, turn_out, move_count, illegal_pulse, game_over
    );

    modport slave (
        output move_valid, pass_in, move_in, upd_next_board, upd_ready,
        input  move_ready, upd_start, upd_move, upd_turn, upd_board,
               board_out, turn_out, move_count, illegal_pulse, game_over
    );
endinterface

// File: rtl/turn_sequencer.sv
// Turn sequencer: accepts moves/passes, runs one board-update request per legal move and owns the
// committed board, turn, ply count and game-over flag. Define KO_CHECK_EN to reject ko repetitions.
module turn_sequencer #(
    parameter int unsigned UPD_TIMEOUT = 4096
) (
    input  logic             clk_in,
    input  logic             rst_in,
    turn_sequencer_if.master io_bus
);

    localparam int unsigned    TmoW    = $clog2(UPD_TIMEOUT);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(UPD_TIMEOUT - 1);

`ifdef KO_CHECK_EN
    typedef enum logic [6:0] {
        StIdle   = 7'b000_0001,
        StCheck  = 7'b000_0010,
        StIssue  = 7'b000_0100,
        StWait   = 7'b000_1000,
        StCommit = 7'b001_0000,
        StOver   = 7'b010_0000,
        StKoCmp  = 7'b100_0000
    } state_e;
`else
    typedef enum logic [5:0] {
        StIdle   = 6'b00_0001,
        StCheck  = 6'b00_0010,
        StIssue  = 6'b00_0100,
        StWait   = 6'b00_1000,
        StCommit = 6'b01_0000,
        StOver   = 6'b10_0000
    } state_e;
`endif

    state_e               r_state;
    logic [8:0][8:0][1:0] r_board;
    logic [8:0][8:0][1:0] r_next_board;
    logic                 r_turn;
    logic [8:0]           r_move_count;
    logic                 r_pass_cnt;
    logic                 r_game_over;
    logic [7:0]           r_move;
    logic [TmoW-1:0]      r_tmo;
    logic                 r_illegal;
    logic                 r_upd_start;
    logic                 r_move_ready;
`ifdef KO_CHECK_EN
    logic [8:0][8:0][1:0] r_prev_board;
`endif

    logic [3:0] w_row;
    logic [3:0] w_col;
    logic       w_off_board;
    logic [1:0] w_cell;
    logic [8:0] w_count_inc;

    assign w_row       = r_move[7:4];
    assign w_col       = r_move[3:0];
    assign w_off_board = (w_row > 4'd8) || (w_col > 4'd8);
    // Never index past the 9x9 board with an off-board coordinate.
    assign w_cell      = w_off_board ? 2'b00 : r_board[w_row][w_col];
    assign w_count_inc = (r_move_count == 9'h1FF) ? r_move_count : r_move_count + 9'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= StIdle;
            r_board      <= '0;
            r_next_board <= '0;
            r_turn       <= 1'b0;
            r_move_count <= '0;
            r_pass_cnt   <= 1'b0;
            r_game_over  <= 1'b0;
            r_move       <= '0;
            r_tmo        <= '0;
            r_illegal    <= 1'b0;
            r_upd_start  <= 1'b0;
            r_move_ready <= 1'b0;
`ifdef KO_CHECK_EN
            r_prev_board <= '0;
`endif
        end else begin
            r_illegal   <= 1'b0;
            r_upd_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_move_ready <= 1'b1;
                    // move_ready is low for the first IDLE cycle after reset.
                    if (r_move_ready) begin
                        if (io_bus.pass_in) begin
                            r_turn       <= ~r_turn;
                            r_move_count <= w_count_inc;
                            if (r_pass_cnt) begin
                                r_state      <= StOver;
                                r_game_over  <= 1'b1;
                                r_move_ready <= 1'b0;
                            end else begin
                                r_pass_cnt <= 1'b1;
                            end
                        end else if (io_bus.move_valid) begin
                            r_move       <= io_bus.move_in;
                            r_state      <= StCheck;
                            r_move_ready <= 1'b0;
                        end
                    end
                end
                StCheck: begin
                    if (w_off_board || (w_cell != 2'b00)) begin
                        r_illegal    <= 1'b1;
                        r_state      <= StIdle;
                        r_move_ready <= 1'b1;
                    end else begin
                        r_upd_start <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_tmo   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (io_bus.upd_ready) begin
                        r_next_board <= io_bus.upd_next_board;
`ifdef KO_CHECK_EN
                        r_state      <= StKoCmp;
`else
                        r_state      <= StCommit;
`endif
                    end else if (r_tmo == TmoLast) begin
                        r_illegal    <= 1'b1;
                        r_state      <= StIdle;
                        r_move_ready <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TmoW'(1);
                    end
                end
`ifdef KO_CHECK_EN
                StKoCmp: begin
                    // Recreating the position from before the last commit is a ko violation.
                    if (r_next_board == r_prev_board) begin
                        r_illegal    <= 1'b1;
                        r_state      <= StIdle;
                        r_move_ready <= 1'b1;
                    end else begin
                        r_state <= StCommit;
                    end
                end
`endif
                StCommit: begin
`ifdef KO_CHECK_EN
                    r_prev_board <= r_board;
`endif
                    r_board      <= r_next_board;
                    r_turn       <= ~r_turn;
                    r_move_count <= w_count_inc;
                    r_pass_cnt   <= 1'b0;
                    r_state      <= StIdle;
                    r_move_ready <= 1'b1;
                end
                StOver: begin
                    r_move_ready <= 1'b0;
                    r_game_over  <= 1'b1;
                end
                default: begin
                    r_state      <= StIdle;
                    r_move_ready <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.move_ready    = r_move_ready;
    assign io_bus.upd_start     = r_upd_start;
    assign io_bus.upd_move      = r_move;
    assign io_bus.upd_turn      = r_turn;
    assign io_bus.upd_board     = r_board;
    assign io_bus.board_out     = r_board;
    assign io_bus.turn_out      = r_turn;
    assign io_bus.move_count    = r_move_count;
    assign io_bus.illegal_pulse = r_illegal;
    assign io_bus.game_over     = r_game_over;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed vector table, handshake corner cases and randomized play
// checked against a game-level model. Build with +define+KO_CHECK_EN for the ko variant.
`timescale 1ns/1ps
module tb_turn_sequencer;
    localparam int unsigned Tmo = 32;
    localparam int          NumVecs = 12;
    typedef logic [8:0][8:0][1:0] board_t;

    typedef struct {
        logic       is_pass;
        logic [7:0] mv;
        int         resp;       // 0 place stone, 1 updater silent, 2 return pre-last-move board
        logic       exp_rej;
        int         exp_count;
        logic       exp_turn;
        logic       exp_over;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    board_t m_board;
    board_t m_prev;
    logic   m_turn;
    logic   m_over;
    int     m_count;
    int     m_passes;
    vec_t   vecs[NumVecs];

    always #5 clk = ~clk;

    turn_sequencer_if bus ();

    turn_sequencer #(.UPD_TIMEOUT(Tmo)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .io_bus (bus)
    );

    function automatic void check(input string name, input logic [161:0] act,
                                  input logic [161:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_board  = '0;
        m_prev   = '0;
        m_turn   = 1'b0;
        m_over   = 1'b0;
        m_count  = 0;
        m_passes = 0;
    endtask

    task automatic cmp_state(input string tag);
        check({tag, ".board"}, bus.board_out, m_board);
        check({tag, ".turn"}, 162'(bus.turn_out), 162'(m_turn));
        check({tag, ".count"}, 162'(bus.move_count), 162'(m_count));
        check({tag, ".over"}, 162'(bus.game_over), 162'(m_over));
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 8 && !bus.move_ready; i++) tick();
        check("wait.move_ready", 162'(bus.move_ready), 162'(1'b1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.move_valid = 1'b0;
        bus.pass_in    = 1'b0;
        bus.upd_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_pass(output logic rej);
        wait_ready();
        bus.pass_in = 1'b1;
        tick();
        bus.pass_in = 1'b0;
        m_turn = ~m_turn;
        if (m_count < 511) m_count++;
        m_passes++;
        if (m_passes >= 2) m_over = 1'b1;
        rej = bus.illegal_pulse;
        check("pass.move_ready", 162'(bus.move_ready), 162'(!m_over));
        check("pass.no_start", 162'(bus.upd_start), 162'(1'b0));
        cmp_state("pass");
    endtask

    task automatic do_move(input logic [7:0] mv, input int resp, output logic rej);
        int     r, c, seen_start, seen_ill, lat;
        logic   legal, ko, got_ill, got_rdy;
        board_t nxt;
        r = int'(mv[7:4]);
        c = int'(mv[3:0]);
        legal = (r <= 8) && (c <= 8);
        if (legal) legal = (m_board[r][c] == 2'b00);
        rej = 1'b0;
        wait_ready();
        bus.move_valid = 1'b1;
        bus.move_in    = mv;
        tick();
        bus.move_valid = 1'b0;
        seen_start = -1;
        seen_ill   = -1;
        for (int i = 1; i <= 4; i++) begin
            if (bus.upd_start) seen_start = i;
            if (bus.illegal_pulse) seen_ill = i;
            if (seen_start >= 0 || seen_ill >= 0) break;
            tick();
        end
        if (!legal) begin
            rej = (seen_ill >= 0);
            check("move.reject_latency", 162'(seen_ill), 162'(2));
            check("move.reject_no_start", 162'(seen_start < 0), 162'(1'b1));
            tick();
            check("move.reject_one_cycle", 162'(bus.illegal_pulse), 162'(1'b0));
        end else begin
            check("move.start_latency", 162'(seen_start), 162'(2));
            check("move.upd_move", 162'(bus.upd_move), 162'(mv));
            check("move.upd_turn", 162'(bus.upd_turn), 162'(m_turn));
            check("move.upd_board", bus.upd_board, m_board);
            tick();
            check("move.start_one_cycle", 162'(bus.upd_start), 162'(1'b0));
            bus.upd_next_board = '1;
            if (resp == 1) begin
                lat = 1;
                while (!bus.illegal_pulse && lat < int'(Tmo) + 8) begin
                    tick();
                    lat++;
                end
                rej = bus.illegal_pulse;
                check($sformatf("move.timeout_window(lat=%0d)", lat),
                      162'(lat >= int'(Tmo) && lat <= int'(Tmo) + 2), 162'(1'b1));
                tick();
                // A response arriving after the timeout must be dropped.
                nxt = m_board;
                nxt[0][0] = 2'b11;
                bus.upd_next_board = nxt;
                bus.upd_ready = 1'b1;
                tick();
                bus.upd_ready = 1'b0;
                tick();
                tick();
                check("late_ready.no_start", 162'(bus.upd_start), 162'(1'b0));
                check("late_ready.move_ready", 162'(bus.move_ready), 162'(1'b1));
            end else begin
                nxt = m_board;
                nxt[r][c] = m_turn ? 2'b10 : 2'b01;
                if (resp == 2) nxt = m_prev;
                repeat ($urandom_range(0, 4)) tick();
                check("move.hold_move", 162'(bus.upd_move), 162'(mv));
                check("move.hold_board", bus.upd_board, m_board);
                bus.upd_next_board = nxt;
                bus.upd_ready = 1'b1;
                tick();
                bus.upd_ready = 1'b0;
                bus.upd_next_board = '1;
`ifdef KO_CHECK_EN
                ko = (nxt == m_prev);
`else
                ko = 1'b0;
`endif
                got_ill = 1'b0;
                got_rdy = 1'b0;
                for (int i = 0; i < 5 && !got_rdy; i++) begin
                    if (bus.illegal_pulse) got_ill = 1'b1;
                    if (bus.move_ready) got_rdy = 1'b1;
                    else tick();
                end
                check("move.back_to_idle", 162'(got_rdy), 162'(1'b1));
                check("move.ko_reject", 162'(got_ill), 162'(ko));
                rej = got_ill;
                if (!ko) begin
                    m_prev  = m_board;
                    m_board = nxt;
                    m_turn  = ~m_turn;
                    if (m_count < 511) m_count++;
                    m_passes = 0;
                end
            end
        end
        cmp_state("move");
    endtask

    task automatic check_over_ignores();
        bus.move_valid = 1'b1;
        bus.move_in    = 8'h22;
        repeat (4) begin
            tick();
            check("over.no_start", 162'(bus.upd_start), 162'(1'b0));
            check("over.no_reject", 162'(bus.illegal_pulse), 162'(1'b0));
        end
        bus.move_valid = 1'b0;
        bus.pass_in    = 1'b1;
        tick();
        bus.pass_in = 1'b0;
        tick();
        check("over.move_ready", 162'(bus.move_ready), 162'(1'b0));
        cmp_state("over");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic   rej;
        int     x, resp;
        board_t nxt;

        vecs[0]  = '{1'b0, 8'h44, 0, 1'b0, 1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h44, 0, 1'b1, 1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h49, 0, 1'b1, 1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h94, 0, 1'b1, 1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h33, 1, 1'b1, 1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 0, 1'b0, 2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 0, 1'b0, 3, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 0, 1'b0, 4, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h88, 0, 1'b0, 5, 1'b1, 1'b0};
`ifdef KO_CHECK_EN
        vecs[9]  = '{1'b0, 8'h12, 2, 1'b1, 5, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 0, 1'b0, 6, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h00, 0, 1'b0, 7, 1'b1, 1'b1};
`else
        vecs[9]  = '{1'b0, 8'h12, 2, 1'b0, 6, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 0, 1'b0, 7, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h00, 0, 1'b0, 8, 1'b0, 1'b1};
`endif

        bus.move_valid     = 1'b0;
        bus.pass_in        = 1'b0;
        bus.move_in        = '0;
        bus.upd_ready      = 1'b0;
        bus.upd_next_board = '0;
        model_clear();

        rst = 1'b1;
        tick();
        tick();
        check("reset.move_ready", 162'(bus.move_ready), 162'(1'b0));
        check("reset.upd_start", 162'(bus.upd_start), 162'(1'b0));
        check("reset.illegal", 162'(bus.illegal_pulse), 162'(1'b0));
        cmp_state("reset");
        rst = 1'b0;
        tick();
        check("reset.ready_rises", 162'(bus.move_ready), 162'(1'b1));

        for (int i = 0; i < NumVecs; i++) begin
            if (vecs[i].is_pass) do_pass(rej);
            else do_move(vecs[i].mv, vecs[i].resp, rej);
            check($sformatf("vec%0d.reject", i), 162'(rej), 162'(vecs[i].exp_rej));
            check($sformatf("vec%0d.count", i), 162'(bus.move_count), 162'(vecs[i].exp_count));
            check($sformatf("vec%0d.turn", i), 162'(bus.turn_out), 162'(vecs[i].exp_turn));
            check($sformatf("vec%0d.over", i), 162'(bus.game_over), 162'(vecs[i].exp_over));
        end
        check_over_ignores();

        do_reset();
        for (int n = 0; n < 60; n++) begin
            if (m_over) begin
                check_over_ignores();
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                do_pass(rej);
            end else begin
                x    = int'($urandom_range(0, 15));
                resp = (x == 0) ? 1 : ((x < 3) ? 2 : 0);
                do_move({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))}, resp, rej);
            end
        end

        // Reset while the updater request is outstanding.
        do_reset();
        do_move(8'h44, 0, rej);
        wait_ready();
        bus.move_valid = 1'b1;
        bus.move_in    = 8'h55;
        tick();
        bus.move_valid = 1'b0;
        for (int i = 0; i < 4 && !bus.upd_start; i++) tick();
        check("rst_mid.start", 162'(bus.upd_start), 162'(1'b1));
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        model_clear();
        check("rst_mid.move_ready", 162'(bus.move_ready), 162'(1'b0));
        cmp_state("rst_mid");
        rst = 1'b0;
        nxt = '0;
        nxt[5][5] = 2'b10;
        bus.upd_next_board = nxt;
        bus.upd_ready = 1'b1;
        tick();
        bus.upd_ready = 1'b0;
        tick();
        tick();
        check("rst_mid.late_ready", 162'(bus.move_ready), 162'(1'b1));
        check("rst_mid.no_start", 162'(bus.upd_start), 162'(1'b0));
        cmp_state("rst_mid.late");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
